mem_stage_memwb: RTL and testbench

- Memory-access stage of the 16-bit pipeline. Consumes the EX/MEM register outputs and resolves branches (PCSrc/target).
- Runs a request/ready handshake to a variable-latency data memory and stalls upstream stages while an access is outstanding.
- Registers results into the MEM/WB pipeline register that feeds write-back.
- Adds a watchdog so a memory that never answers cannot hang the pipeline.

---
 rtl/mem_stage_memwb.sv | 159 +++++++++++++++
 tb/tb_mem_stage_memwb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_memwb.sv
// MEM stage of the 16-bit pipeline: branch resolution, handshaked data-memory access
// with a watchdog, and the MEM/WB pipeline register feeding write-back.
module mem_stage_memwb #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ValidIn,
  input  logic              ZeroIn,
  input  logic [1:0]        WBIn,
  input  logic [2:0]        MIn,
  input  logic [DATA_W-1:0] PcAddIn,
  input  logic [DATA_W-1:0] AluOutIn,
  input  logic [DATA_W-1:0] ReadData2In,
  input  logic [REG_W-1:0]  TRegIn,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              Stall,
  output logic              MemReq,
  output logic              MemWe,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemRData,
  output logic              MemErr,
  output logic              ValidOut,
  output logic [1:0]        WBOut,
  output logic [DATA_W-1:0] ReadDataOut,
  output logic [DATA_W-1:0] AluOutOut,
  output logic [REG_W-1:0]  TRegOut
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              stateQ, stateD;
  logic [CNT_W-1:0]    countQ, countD;
  logic                memReqQ, memReqD;
  logic                memWeQ, memWeD;
  logic [DATA_W-1:0]   memAddrQ, memAddrD;
  logic [DATA_W-1:0]   memWDataQ, memWDataD;
  logic                memErrQ, memErrD;
  logic                validQ, validD;
  logic [1:0]          wbQ, wbD;
  logic [DATA_W-1:0]   readDataQ, readDataD;
  logic [DATA_W-1:0]   aluQ, aluD;
  logic [REG_W-1:0]    tRegQ, tRegD;

  logic memOp;
  logic countLast;

  assign memOp        = ValidIn & (MIn[1] | MIn[0]);
  assign countLast    = (countQ == CNT_W'(TIMEOUT - 1));
  assign PCSrc        = ValidIn & MIn[2] & ZeroIn;
  assign BranchTarget = PcAddIn;

  // An aborting access releases the pipeline in the same cycle it gives up.
  always_comb begin
    Stall = 1'b0;
    if (stateQ == IDLE) begin
      Stall = memOp;
    end else begin
      Stall = ~MemReady & ~countLast;
    end
  end

  always_comb begin
    stateD    = stateQ;
    countD    = countQ;
    memReqD   = memReqQ;
    memWeD    = memWeQ;
    memAddrD  = memAddrQ;
    memWDataD = memWDataQ;
    memErrD   = memErrQ;
    validD    = 1'b0;
    wbD       = 2'b00;
    readDataD = '0;
    aluD      = AluOutIn;
    tRegD     = TRegIn;
    case (stateQ)
      IDLE: begin
        if (memOp) begin
          stateD    = ACCESS;
          memReqD   = 1'b1;
          memWeD    = MIn[0];
          memAddrD  = AluOutIn;
          memWDataD = ReadData2In;
          countD    = '0;
        end else begin
          validD = ValidIn;
          wbD    = ValidIn ? WBIn : 2'b00;
        end
      end
      ACCESS: begin
        if (MemReady) begin
          validD    = 1'b1;
          wbD       = WBIn;
          readDataD = memWeQ ? '0 : MemRData;
          memReqD   = 1'b0;
          stateD    = IDLE;
        end else if (countLast) begin
          // Watchdog abort: the instruction retires but must not write back.
          memErrD = 1'b1;
          memReqD = 1'b0;
          validD  = 1'b1;
          stateD  = IDLE;
        end else if (countQ != '1) begin
          countD = countQ + CNT_W'(1);
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ    <= IDLE;
      countQ    <= '0;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWDataQ <= '0;
      memErrQ   <= 1'b0;
      validQ    <= 1'b0;
      wbQ       <= 2'b00;
      readDataQ <= '0;
      aluQ      <= '0;
      tRegQ     <= '0;
    end else begin
      stateQ    <= stateD;
      countQ    <= countD;
      memReqQ   <= memReqD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memWDataQ <= memWDataD;
      memErrQ   <= memErrD;
      validQ    <= validD;
      wbQ       <= wbD;
      readDataQ <= readDataD;
      aluQ      <= aluD;
      tRegQ     <= tRegD;
    end
  end

  assign MemReq      = memReqQ;
  assign MemWe       = memWeQ;
  assign MemAddr     = memAddrQ;
  assign MemWData    = memWDataQ;
  assign MemErr      = memErrQ;
  assign ValidOut    = validQ;
  assign WBOut       = wbQ;
  assign ReadDataOut = readDataQ;
  assign AluOutOut   = aluQ;
  assign TRegOut     = tRegQ;

endmodule

// File: tb/tb_mem_stage_memwb.sv
// Scoreboard bench for mem_stage_memwb: a driver predicts each retirement from the
// instruction and its chosen memory latency, a memory model answers requests, a monitor checks.
`timescale 1ns/1ps
module tb_mem_stage_memwb;

  localparam int TIMEOUT = 15;

  logic        Clk, Rst_n;
  logic        ValidIn, ZeroIn;
  logic [1:0]  WBIn;
  logic [2:0]  MIn;
  logic [15:0] PcAddIn, AluOutIn, ReadData2In;
  logic [2:0]  TRegIn;
  logic        PCSrc, Stall, MemReq, MemWe, MemReady, MemErr, ValidOut;
  logic [15:0] BranchTarget, MemAddr, MemWData, MemRData, ReadDataOut, AluOutOut;
  logic [1:0]  WBOut;
  logic [2:0]  TRegOut;

  typedef struct {
    logic [1:0]  wb;
    logic [15:0] rd;
    logic [15:0] alu;
    logic [2:0]  treg;
    logic        abort;
  } expT;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } reqT;

  expT expQ[$];
  reqT reqQ[$];
  int  latQ[$];
  int  total = 0;
  int  bad = 0;
  logic expErr = 1'b0;

  mem_stage_memwb #(.DATA_W(16), .REG_W(3), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ValidIn(ValidIn), .ZeroIn(ZeroIn), .WBIn(WBIn), .MIn(MIn),
    .PcAddIn(PcAddIn), .AluOutIn(AluOutIn), .ReadData2In(ReadData2In), .TRegIn(TRegIn),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Stall(Stall), .MemReq(MemReq),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemReady(MemReady),
    .MemRData(MemRData), .MemErr(MemErr), .ValidOut(ValidOut), .WBOut(WBOut),
    .ReadDataOut(ReadDataOut), .AluOutOut(AluOutOut), .TRegOut(TRegOut)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstMemReq", MemReq, 0);
    checkOutput("rstMemWe", MemWe, 0);
    checkOutput("rstMemAddr", MemAddr, 0);
    checkOutput("rstMemWData", MemWData, 0);
    checkOutput("rstMemErr", MemErr, 0);
    checkOutput("rstValidOut", ValidOut, 0);
    checkOutput("rstWBOut", WBOut, 0);
    checkOutput("rstReadData", ReadDataOut, 0);
    checkOutput("rstAluOut", AluOutOut, 0);
    checkOutput("rstTRegOut", TRegOut, 0);
  endtask

  // Present one EX/MEM instruction, predict its retirement, and hold it while stalled.
  task automatic applyStimulus(input logic v, input logic zero, input logic [1:0] wb,
                               input logic [2:0] m, input logic [15:0] pcAdd,
                               input logic [15:0] alu, input logic [15:0] rd2,
                               input logic [2:0] treg, input int lat, input logic [15:0] rdata);
    logic isMem, isWrite, abort;
    int expStall, stallCnt;
    expT e;
    reqT r;
    @(posedge Clk); #1;
    ValidIn = v; ZeroIn = zero; WBIn = wb; MIn = m; PcAddIn = pcAdd;
    AluOutIn = alu; ReadData2In = rd2; TRegIn = treg;
    isMem   = v && (m[1] || m[0]);
    isWrite = m[0];
    abort   = isMem && (lat >= TIMEOUT);
    if (isMem) begin
      r.we = isWrite; r.addr = alu; r.wdata = rd2; r.rdata = rdata;
      reqQ.push_back(r);
      latQ.push_back(lat);
      expStall = abort ? TIMEOUT : lat + 1;
    end else begin
      expStall = 0;
    end
    if (v) begin
      e.wb    = abort ? 2'b00 : wb;
      e.rd    = (isMem && !isWrite && !abort) ? rdata : 16'h0000;
      e.alu   = alu;
      e.treg  = treg;
      e.abort = abort;
      expQ.push_back(e);
    end
    @(negedge Clk);
    checkOutput("pcSrc", PCSrc, v & m[2] & zero);
    checkOutput("branchTarget", BranchTarget, pcAdd);
    stallCnt = 0;
    while (Stall) begin
      stallCnt++;
      if (stallCnt > TIMEOUT + 8) begin
        $display("[TB] FAIL stallBound actual=%0d required=%0d", stallCnt, expStall);
        bad++; total++;
        break;
      end
      @(negedge Clk);
    end
    checkOutput("stallCycles", stallCnt, expStall);
  endtask

  // Memory model: answers each request after the latency the driver chose for it.
  initial begin
    int k, lat;
    bit inReq;
    reqT r;
    MemReady = 1'b0; MemRData = '0; inReq = 0; k = 0; lat = 0;
    r = '{we: 1'b0, addr: 16'h0, wdata: 16'h0, rdata: 16'h0};
    forever begin
      @(posedge Clk); #1;
      if (!Rst_n || !MemReq) begin
        inReq = 0;
        MemReady = Rst_n ? 1'($urandom) : 1'b0;
        MemRData = 16'($urandom);
      end else begin
        if (!inReq) begin
          inReq = 1; k = 0;
          if (latQ.size() == 0 || reqQ.size() == 0) begin
            $display("[TB] FAIL unexpectedReq actual=MemReq=1 required=no request");
            bad++; total++;
            lat = 0;
          end else begin
            lat = latQ.pop_front();
            r = reqQ.pop_front();
          end
        end else begin
          k++;
        end
        checkOutput("memWe", MemWe, r.we);
        checkOutput("memAddr", MemAddr, r.addr);
        if (r.we) checkOutput("memWData", MemWData, r.wdata);
        MemReady = (k == lat);
        MemRData = (k == lat) ? r.rdata : 16'($urandom);
      end
    end
  end

  // Monitor: every valid MEM/WB slot must match the oldest predicted retirement.
  initial begin
    expT e;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        expErr = 1'b0;
      end else begin
        if (ValidOut) begin
          if (expQ.size() == 0) begin
            $display("[TB] FAIL unexpectedValid actual=ValidOut=1 required=ValidOut=0 at %0t", $time);
            bad++; total++;
          end else begin
            e = expQ.pop_front();
            checkOutput("wbOut", WBOut, e.wb);
            checkOutput("readDataOut", ReadDataOut, e.rd);
            checkOutput("aluOutOut", AluOutOut, e.alu);
            checkOutput("tRegOut", TRegOut, e.treg);
            if (e.abort) expErr = 1'b1;
          end
        end
        checkOutput("memErr", MemErr, expErr);
      end
    end
  end

  task automatic runRandom(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                        : $urandom_range(0, 5);
      applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 3'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), lat,
                    16'($urandom));
    end
    applyStimulus(0, 0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
    repeat (3) @(negedge Clk);
    checkOutput("scoreboardDrained", expQ.size(), 0);
  endtask

  initial begin
    Rst_n = 1'b1; ValidIn = 0; ZeroIn = 0; WBIn = 0; MIn = 0;
    PcAddIn = 0; AluOutIn = 0; ReadData2In = 0; TRegIn = 0;
    #2 Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 checkResetOutputs();
    checkOutput("rstStall", Stall, 0);
    @(negedge Clk) Rst_n = 1'b1;

    applyStimulus(1, 0, 2'b01, 3'b000, 16'h0000, 16'h1234, 16'h0000, 3'd5, 0, 16'h0);
    applyStimulus(1, 0, 2'b11, 3'b010, 16'h0000, 16'h0040, 16'h0000, 3'd3, 3, 16'hBEEF);
    applyStimulus(1, 0, 2'b00, 3'b001, 16'h0000, 16'h0080, 16'h00AA, 3'd2, 0, 16'h5555);
    applyStimulus(1, 0, 2'b11, 3'b010, 16'h0000, 16'h0044, 16'h0000, 3'd4, TIMEOUT, 16'hDEAD);
    applyStimulus(1, 0, 2'b11, 3'b010, 16'h0000, 16'h0046, 16'h0000, 3'd6, 2, 16'h1357);
    applyStimulus(1, 0, 2'b11, 3'b010, 16'h0000, 16'h0048, 16'h0000, 3'd1, TIMEOUT - 1, 16'h2468);
    applyStimulus(1, 0, 2'b01, 3'b011, 16'h0000, 16'h004A, 16'h0F0F, 3'd7, 1, 16'hFFFF);
    applyStimulus(0, 0, 2'b11, 3'b010, 16'h0000, 16'h004C, 16'h0000, 3'd3, 0, 16'h0);
    applyStimulus(1, 1, 2'b00, 3'b100, 16'h0020, 16'h0000, 16'h0000, 3'd0, 0, 16'h0);
    applyStimulus(1, 0, 2'b00, 3'b100, 16'h0020, 16'h0000, 16'h0000, 3'd0, 0, 16'h0);
    applyStimulus(0, 1, 2'b00, 3'b100, 16'h0020, 16'h0000, 16'h0000, 3'd0, 0, 16'h0);

    runRandom(200);

    // Reset in the middle of an outstanding load must drop the request at once.
    @(posedge Clk); #1;
    ValidIn = 1; MIn = 3'b010; WBIn = 2'b11; AluOutIn = 16'h0100; TRegIn = 3'd2;
    reqQ.push_back('{we: 1'b0, addr: 16'h0100, wdata: 16'h0, rdata: 16'h0});
    latQ.push_back(50);
    repeat (3) @(posedge Clk);
    #1 checkOutput("preRstMemReq", MemReq, 1);
    #2 Rst_n = 1'b0; ValidIn = 0; MIn = 3'b000;
    #1 checkResetOutputs();
    repeat (2) @(posedge Clk);
    expQ.delete(); reqQ.delete(); latQ.delete();
    @(negedge Clk) Rst_n = 1'b1;
    #1 checkOutput("postRstStall", Stall, 0);
    checkOutput("postRstMemReq", MemReq, 0);

    runRandom(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
